// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit between the hart datapath and a handshaked data memory
//
// Purpose: accepts one load/store at a time, traps on misalignment or illegal
// funct3, drives an aligned word address with byte mask and lane-shifted store
// data, waits for the memory response (with optional timeout) and returns
// extended load data or a trap as a one-cycle response pulse.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_*, o_req_ready         core request (valid/ready, wen, funct3, addr, wdata)
//   o_rsp_valid/rdata/trap       registered one-cycle response to the core
//   o_mem_addr/ren/wen/wdata/mask  memory request, held stable in REQ
//   i_mem_ready/valid/rdata      memory accept, response/ack and read word
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam bit LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_wen;
  logic [2:0]           r_funct3;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_trap;

  logic        w_accept;
  logic        w_req_trap;
  logic        w_capture;
  logic        w_rsp_trap;
  logic        w_timeout;
  logic        w_in_req;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_rword;
  logic [31:0] w_load_data;

  assign w_accept = i_req_valid && (r_state == S_IDLE);
  assign w_in_req = (r_state == S_REQ);
  assign w_off    = r_addr[1:0];

  // Legality of the incoming request; funct3[1:0] encodes the access size.
  always_comb begin
    w_req_trap = 1'b0;
    if (i_req_wen) begin
      w_req_trap = (i_req_funct3 > 3'd2);
    end else begin
      w_req_trap = (i_req_funct3 == 3'd3) || (i_req_funct3[2:1] == 2'b11);
    end
    if ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) begin
      w_req_trap = 1'b1;
    end
    if ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)) begin
      w_req_trap = 1'b1;
    end
  end

  // A response arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout = LP_TO_EN && (r_cnt == LP_CNT_LAST) && !i_mem_valid;

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_rsp_trap = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_trap) begin
            w_next     = S_RESP;
            w_rsp_trap = 1'b1;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_mem_ready) begin
          if (i_mem_valid) begin
            w_next    = S_RESP;
            w_capture = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_mem_valid) begin
          w_next    = S_RESP;
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_next     = S_RESP;
          w_rsp_trap = 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Byte-lane mask from access size and offset.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_mask = 4'b0001 << w_off;
      2'b01:   w_mask = 4'b0011 << w_off;
      default: w_mask = 4'b1111;
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend.
  assign w_rword = i_mem_rdata >> {w_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_rword[7]}}, w_rword[7:0]};
      3'd1:    w_load_data = {{16{w_rword[15]}}, w_rword[15:0]};
      3'd4:    w_load_data = {24'b0, w_rword[7:0]};
      3'd5:    w_load_data = {16'b0, w_rword[15:0]};
      default: w_load_data = w_rword;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wen       <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_trap  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_wen    <= i_req_wen;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
      end
      // Response registers are only non-zero during the single RESP cycle.
      r_rsp_trap  <= w_rsp_trap;
      r_rsp_rdata <= (w_capture && !r_wen) ? w_load_data : 32'd0;
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_trap  = r_rsp_trap;
  assign o_mem_ren   = w_in_req && !r_wen;
  assign o_mem_wen   = w_in_req && r_wen;
  assign o_mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_mem_mask  = w_in_req ? w_mask : 4'b0000;
  assign o_mem_wdata = w_in_req ? (r_wdata << {w_off, 3'b000}) : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_trap;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wen(i_req_wen), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3 % 4)
      0: return 1;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal(input bit wen, input logic [2:0] f3, input logic [31:0] addr);
    bit f3_ok;
    if (wen) f3_ok = (f3 <= 2);
    else     f3_ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return f3_ok && ((addr % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] h;
    s = w >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      2: return s;
      4: return b;
      5: return h;
      default: return 32'd0;
    endcase
  endfunction

  // rdy_dly: REQ cycles with ready low before ready.
  // vwait: 0 = valid with ready in REQ; k = valid on k-th WAIT cycle; large = never.
  task automatic txn(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rword,
                     input int rdy_dly, input int vwait);
    int          off;
    int          nb;
    bit          timed_out;
    logic [31:0] exp_mask;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    off       = addr % 4;
    nb        = size_of(f3);
    exp_mask  = (((1 << nb) - 1) << off) % 16;
    exp_wd    = wd << (8 * off);
    timed_out = 1'b0;

    check("accept_ready", o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_wen    = wen;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    step();
    i_req_valid  = 1'b0;
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
    i_req_funct3 = 3'($urandom);
    i_req_wen    = 1'($urandom);

    if (!legal(wen, f3, addr)) begin
      check("trap_valid", o_rsp_valid, 1);
      check("trap_flag", o_rsp_trap, 1);
      check("trap_rdata", o_rsp_rdata, 0);
      check("trap_no_strobe", {o_mem_ren, o_mem_wen}, 0);
      step();
      check("trap_after_valid", o_rsp_valid, 0);
      check("trap_after_ready", o_req_ready, 1);
      return;
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      check("req_ren", o_mem_ren, !wen);
      check("req_wen", o_mem_wen, wen);
      check("req_addr", o_mem_addr, addr & 32'hFFFF_FFFC);
      check("req_mask", o_mem_mask, exp_mask);
      if (wen) check("req_wdata", o_mem_wdata, exp_wd);
      check("req_no_rsp", {o_rsp_valid, o_req_ready}, 0);
      i_mem_ready = (c == rdy_dly);
      i_mem_valid = (c == rdy_dly) && (vwait == 0);
      i_mem_rdata = i_mem_valid ? rword : $urandom;
      step();
    end
    i_mem_ready = 1'b0;
    i_mem_valid = 1'b0;

    if (vwait != 0) begin
      for (int c = 1; c <= TO; c++) begin
        check("wait_no_strobe", {o_mem_ren, o_mem_wen}, 0);
        check("wait_no_rsp", o_rsp_valid, 0);
        i_mem_valid = (c == vwait);
        i_mem_rdata = i_mem_valid ? rword : $urandom;
        step();
        i_mem_valid = 1'b0;
        if (c == vwait) break;
        if (c == TO) timed_out = 1'b1;
      end
    end

    exp_rd = (timed_out || wen) ? 32'd0 : load_model(f3, off, rword);
    check("rsp_valid", o_rsp_valid, 1);
    check("rsp_trap", o_rsp_trap, timed_out);
    check("rsp_rdata", o_rsp_rdata, exp_rd);
    check("rsp_not_ready", o_req_ready, 0);
    step();
    check("post_valid", o_rsp_valid, 0);
    check("post_ready", o_req_ready, 1);
    check("post_rdata", {o_rsp_trap, o_rsp_rdata}, 0);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_wen    = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    i_mem_ready  = 1'b0;
    i_mem_valid  = 1'b0;
    i_mem_rdata  = 32'd0;
    step();
    step();
    i_rst = 1'b0;

    check("rst_ready", o_req_ready, 1);
    check("rst_rsp", {o_rsp_valid, o_rsp_trap}, 0);
    check("rst_strobes", {o_mem_ren, o_mem_wen}, 0);
    check("rst_rdata", o_rsp_rdata, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_mask", o_mem_mask, 0);

    // directed cases
    txn(0, 3'd2, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    txn(0, 3'd0, 32'h0000_2003, 32'h0, 32'h8012_3456, 0, 0);
    txn(0, 3'd4, 32'h0000_2003, 32'h0, 32'h8012_3456, 0, 0);
    txn(0, 3'd5, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0);
    txn(1, 3'd0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 3, 1);
    txn(0, 3'd2, 32'h0000_1002, 32'h0, 32'h0, 0, 0);
    txn(1, 3'd1, 32'h0000_1001, 32'h1234, 32'h0, 0, 0);
    txn(0, 3'd3, 32'h0000_1000, 32'h0, 32'h0, 0, 0);
    txn(0, 3'd2, 32'h0000_1004, 32'h0, 32'h1111_2222, 0, 100);
    txn(0, 3'd2, 32'h0000_1004, 32'h0, 32'h3333_4444, 0, 4);
    txn(0, 3'd1, 32'h0000_1006, 32'h0, 32'h8001_0000, 1, 2);

    // reset while in WAIT
    i_req_valid  = 1'b1;
    i_req_wen    = 1'b0;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h0000_4000;
    step();
    i_req_valid = 1'b0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("midrst_ready", o_req_ready, 1);
    check("midrst_rsp", o_rsp_valid, 0);
    check("midrst_strobes", {o_mem_ren, o_mem_wen}, 0);
    i_mem_valid = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    step();
    i_mem_valid = 1'b0;
    check("stale_rsp", o_rsp_valid, 0);
    check("stale_ready", o_req_ready, 1);
    step();
    check("stale_rsp2", o_rsp_valid, 0);
    txn(0, 3'd2, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 0, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      bit          wen;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          vw;
      wen  = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[0] = 1'b0;
      if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
      vw = $urandom_range(0, 6);
      if (vw == 6) vw = 100;
      txn(wen, f3, addr, $urandom, $urandom, $urandom_range(0, 2), vw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
